// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, forwards from EX/MEM/WB,
// stalls on load-use and holds the ID/EX register under valid/ready.
module operand_fetch #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [4:0]        in_ra1,
   input  logic [4:0]        in_ra2,
   input  logic              in_use1,
   input  logic              in_use2,
   input  logic [4:0]        in_wa,
   input  logic              in_wen,
   input  logic              in_is_load,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_ra1,
   output logic [4:0]        rf_ra2,
   input  logic [31:0]       rf_rd1,
   input  logic [31:0]       rf_rd2,
   input  logic              ex_wen,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_wa,
   input  logic [31:0]       ex_wd,
   input  logic              mem_wen,
   input  logic              mem_data_ok,
   input  logic [4:0]        mem_wa,
   input  logic [31:0]       mem_wd,
   input  logic              wb_wen,
   input  logic [4:0]        wb_wa,
   input  logic [31:0]       wb_wd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_op1,
   output logic [31:0]       out_op2,
   output logic [31:0]       out_imm,
   output logic [4:0]        out_wa,
   output logic              out_wen,
   output logic              out_is_load,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [4:0]  src [2];
   logic [31:0] rd  [2];
   logic        used [2];
   logic [31:0] op  [2];
   logic        hazard;
   logic        advance;
   logic        accept;

   assign rf_ra1   = in_ra1;
   assign rf_ra2   = in_ra2;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush && resetn;
   assign accept   = !flush && advance && in_valid && !hazard;

   // Forwarding mux and hazard detect for both sources. A matching EX
   // instruction (load or not) shadows any older MEM match for hazard
   // purposes, since EX holds the youngest producer.
   always_comb begin
      src[0]  = in_ra1;
      src[1]  = in_ra2;
      rd[0]   = rf_rd1;
      rd[1]   = rf_rd2;
      used[0] = in_use1;
      used[1] = in_use2;
      hazard  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (src[i] == 5'd0)
            op[i] = 32'd0;
         else if (ex_wen && ex_wa == src[i] && !ex_is_load)
            op[i] = ex_wd;
         else if (mem_wen && mem_wa == src[i] && mem_data_ok)
            op[i] = mem_wd;
         else if (wb_wen && wb_wa == src[i])
            op[i] = wb_wd;
         else
            op[i] = rd[i];

         if (used[i] && src[i] != 5'd0) begin
            if (ex_wen && ex_wa == src[i]) begin
               if (ex_is_load)
                  hazard = 1'b1;
            end else if (mem_wen && mem_wa == src[i] && !mem_data_ok) begin
               hazard = 1'b1;
            end
         end
      end
   end

   // ID/EX pipeline register: flush, load, bubble or hold.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_op1     <= '0;
         out_op2     <= '0;
         out_imm     <= '0;
         out_wa      <= '0;
         out_wen     <= 1'b0;
         out_is_load <= 1'b0;
         out_ctrl    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_pc      <= in_pc;
         out_op1     <= op[0];
         out_op2     <= op[1];
         out_imm     <= in_imm;
         out_wa      <= in_wa;
         out_wen     <= in_wen;
         out_is_load <= in_is_load;
         out_ctrl    <= in_ctrl;
      end else if (advance) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of cycles where a hazard held back a valid input.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         stall_cnt <= '0;
      else if (in_valid && hazard && !flush && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a scoreboard queue and a monitor.
module tb_operand_fetch;

   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_imm;
   logic [4:0]  in_ra1, in_ra2, in_wa;
   logic        in_use1, in_use2, in_wen, in_is_load;
   logic [15:0] in_ctrl;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        ex_wen, ex_is_load;
   logic [4:0]  ex_wa;
   logic [31:0] ex_wd;
   logic        mem_wen, mem_data_ok;
   logic [4:0]  mem_wa;
   logic [31:0] mem_wd;
   logic        wb_wen;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_op1, out_op2, out_imm;
   logic [4:0]  out_wa;
   logic        out_wen, out_is_load;
   logic [15:0] out_ctrl;
   logic [CNT_W-1:0] stall_cnt;

   operand_fetch #(.CTRL_W(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ra1(in_ra1), .in_ra2(in_ra2), .in_use1(in_use1),
      .in_use2(in_use2), .in_wa(in_wa), .in_wen(in_wen), .in_is_load(in_is_load),
      .in_imm(in_imm), .in_ctrl(in_ctrl), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
      .ex_wa(ex_wa), .ex_wd(ex_wd), .mem_wen(mem_wen), .mem_data_ok(mem_data_ok),
      .mem_wa(mem_wa), .mem_wd(mem_wd), .wb_wen(wb_wen), .wb_wa(wb_wa),
      .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
      .out_wa(out_wa), .out_wen(out_wen), .out_is_load(out_is_load),
      .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, op1, op2, imm;
      logic [4:0]  wa;
      logic        wen, ld;
      logic [15:0] ctrl;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_stall = 0;

   localparam logic [31:0] RD1 = 32'h1000_0001;
   localparam logic [31:0] RD2 = 32'h2000_0002;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every ID/EX transfer to execute is matched against the queue.
   always @(negedge clk) begin
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got pc 0x%08h expected none", out_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_op1", out_op1, e.op1);
            chk("out_op2", out_op2, e.op2);
            chk("out_imm", out_imm, e.imm);
            chk("out_ctrl_bundle", {8'd0, out_ctrl, out_wa, out_wen, out_is_load},
                {8'd0, e.ctrl, e.wa, e.wen, e.ld});
         end
      end
   end

   task automatic clear_env();
      ex_wen = 0; ex_is_load = 0; ex_wa = 0; ex_wd = 0;
      mem_wen = 0; mem_data_ok = 0; mem_wa = 0; mem_wd = 0;
      wb_wen = 0; wb_wa = 0; wb_wd = 0;
      rf_rd1 = RD1; rf_rd2 = RD2; flush = 0;
   endtask

   // Present one instruction for one cycle; side fields derive from pc.
   task automatic issue(input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic use1, input logic use2,
                        input logic [31:0] e1, input logic [31:0] e2, input logic acc);
      exp_t e;
      in_valid = 1; in_pc = pc; in_ra1 = ra1; in_ra2 = ra2;
      in_use1 = use1; in_use2 = use2;
      in_wa = pc[4:0]; in_wen = pc[2]; in_is_load = pc[3];
      in_imm = pc ^ 32'hA5A5_0000; in_ctrl = pc[15:0] ^ 16'h3C3C;
      if (acc) begin
         e.pc = pc; e.op1 = e1; e.op2 = e2; e.imm = in_imm;
         e.wa = in_wa; e.wen = in_wen; e.ld = in_is_load; e.ctrl = in_ctrl;
         sb.push_back(e);
      end
      @(negedge clk);
      chk("rf_ra1", {27'd0, rf_ra1}, {27'd0, ra1});
      chk("in_ready", {31'd0, in_ready}, {31'd0, acc});
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   initial begin
      resetn = 0; in_valid = 0; out_ready = 1;
      in_pc = 0; in_ra1 = 0; in_ra2 = 0; in_use1 = 0; in_use2 = 0;
      in_wa = 0; in_wen = 0; in_is_load = 0; in_imm = 0; in_ctrl = 0;
      clear_env();
      #3;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;

      // Forwarding priority EX > MEM > WB > register file.
      ex_wen = 1; ex_wa = 5; ex_wd = 32'h11;
      mem_wen = 1; mem_wa = 5; mem_data_ok = 1; mem_wd = 32'h22;
      wb_wen = 1; wb_wa = 5; wb_wd = 32'h33; rf_rd1 = 32'h44;
      issue(32'h100, 5'd5, 5'd7, 1, 1, 32'h11, RD2, 1);
      ex_wen = 0;
      issue(32'h104, 5'd5, 5'd7, 1, 1, 32'h22, RD2, 1);
      mem_wen = 0;
      issue(32'h108, 5'd5, 5'd7, 1, 1, 32'h33, RD2, 1);
      wb_wen = 0;
      issue(32'h10C, 5'd5, 5'd7, 1, 1, 32'h44, RD2, 1);
      clear_env();

      // Register 0 is never forwarded nor a hazard source.
      ex_wen = 1; ex_wa = 0; ex_wd = 32'hFFFF;
      issue(32'h110, 5'd1, 5'd0, 1, 1, RD1, 32'd0, 1);
      ex_is_load = 1;
      issue(32'h114, 5'd0, 5'd0, 1, 1, 32'd0, 32'd0, 1);
      clear_env();
      chk("r0_no_stall", {28'd0, stall_cnt}, exp_stall);

      // Load-use: one bubble, then MEM supplies the loaded value.
      ex_wen = 1; ex_is_load = 1; ex_wa = 3;
      issue(32'h120, 5'd3, 5'd2, 1, 1, 0, 0, 0);
      exp_stall++;
      chk("loaduse_bubble", {31'd0, out_valid}, 32'd0);
      chk("loaduse_stall_cnt", {28'd0, stall_cnt}, exp_stall);
      clear_env();
      mem_wen = 1; mem_wa = 3; mem_data_ok = 1; mem_wd = 32'hABCD;
      issue(32'h120, 5'd3, 5'd2, 1, 1, 32'hABCD, RD2, 1);
      clear_env();
      // Unused source does not stall.
      ex_wen = 1; ex_is_load = 1; ex_wa = 3;
      issue(32'h124, 5'd3, 5'd2, 0, 1, RD1, RD2, 1);
      clear_env();
      // MEM value not yet available stalls; a younger EX producer masks it.
      mem_wen = 1; mem_wa = 4; mem_data_ok = 0; mem_wd = 32'hDEAD;
      issue(32'h128, 5'd1, 5'd4, 1, 1, 0, 0, 0);
      exp_stall++;
      chk("mem_stall_cnt", {28'd0, stall_cnt}, exp_stall);
      ex_wen = 1; ex_wa = 4; ex_wd = 32'h55;
      issue(32'h128, 5'd1, 5'd4, 1, 1, RD1, 32'h55, 1);
      clear_env();

      // Backpressure: held output, no acceptance, then release.
      issue(32'h200, 5'd1, 5'd2, 1, 1, RD1, RD2, 1);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         issue(32'h204, 5'd6, 5'd2, 1, 1, 0, 0, 0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_pc", out_pc, 32'h200);
         chk("bp_out_op1", out_op1, RD1);
      end
      chk("bp_no_stall", {28'd0, stall_cnt}, exp_stall);
      out_ready = 1;
      issue(32'h204, 5'd6, 5'd2, 1, 1, RD1, RD2, 1);

      // Flush discards the input and empties ID/EX.
      issue(32'h300, 5'd1, 5'd2, 1, 1, RD1, RD2, 1);
      flush = 1;
      issue(32'h304, 5'd1, 5'd2, 1, 1, 0, 0, 0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      ex_wen = 1; ex_is_load = 1; ex_wa = 3;
      issue(32'h308, 5'd3, 5'd2, 1, 1, 0, 0, 0);
      chk("flush_hazard_stall_cnt", {28'd0, stall_cnt}, exp_stall);
      flush = 0;

      // Saturation of the stall counter.
      for (int i = 0; i < 16; i++)
         issue(32'h30C, 5'd3, 5'd2, 1, 1, 0, 0, 0);
      chk("stall_cnt_sat", {28'd0, stall_cnt}, 32'hF);
      clear_env();

      // Asynchronous reset while ID/EX holds a live instruction.
      issue(32'h400, 5'd1, 5'd2, 1, 1, RD1, RD2, 1);
      out_ready = 0;
      #2;
      chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
      resetn = 0;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_out_op1", out_op1, 32'd0);
      chk("async_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
      sb.delete();
      @(negedge clk);
      resetn = 1;
      out_ready = 1;
      @(posedge clk);
      #1;
      issue(32'h500, 5'd8, 5'd9, 1, 1, RD1, RD2, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
